fwrisc_fetch_stream_checker: RTL and testbench
==============================================

Name: fwrisc_fetch_stream_checker

Overview:
Parametrised, synthesizable checker that sits beside the fwrisc fetch unit in formal and simulation benches. It tracks every ivalid/iready word fetch against each instruction delivered on fetch_valid. It checks fetch count, fetch addresses, sequential-PC continuity and, optionally, instruction content. It reports violations as a pulse plus a sticky first-error code, so a bench or formal wrapper can assert on them.

Parameters:
FETCH_DEPTH, 2, capture-buffer slots; must be ≥2.
COUNT_W, 8, width of the instr_count and fetch_count counters.
RESET_PC, 32'h8000_0000, PC used for the continuity check on the first instruction after reset.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
next_pc  in  32  PC of the instruction being fetched
next_pc_seq  in  1  next_pc is sequential to the previous instruction
iaddr  in  32  fetch bus address
idata  in  32  fetch bus read data
ivalid  in  1  fetch request valid
iready  in  1  fetch data ready; a word transfers when ivalid&&iready
fetch_valid  in  1  fetch unit presents instr
decode_complete  in  1  decode has consumed instr
instr  in  32  delivered instruction, raw; low 16 bits are meaningful when instr_c=1
instr_c  in  1  delivered instruction is compressed
err_pulse  out  1  high in any cycle a violation is detected
err_sticky  out  1  set on the first violation; cleared only by reset
err_code  out  3  code of the first violation; 0 = none
instr_count  out  COUNT_W  instructions completed (decode_complete in WAIT_DECODE)
fetch_count  out  COUNT_W  word transfers accepted

Behaviour:
- Reset: all outputs 0; state=IDLE; buffer count nf=0; first_instr=1; last_pc=RESET_PC; last_c=0.
- Capture: on ivalid&&iready, store {iaddr, idata} at slot nf and increment nf. fetch_count increments and wraps modulo 2^COUNT_W.
- If nf==FETCH_DEPTH, the word is dropped and OVERFLOW (1) is raised.
- Address check on each capture: slot 0 requires iaddr=={next_pc[31:2],2'b00}; slot k>0 requires iaddr==slot(k-1) address+4. A mismatch raises ADDR (2).
- State IDLE, fetch_valid=1:
  - Expected word count exp = (next_pc[1] && !instr_c) ? 2 : 1. nf!=exp raises COUNT (3).
  - If next_pc_seq && !first_instr, next_pc must equal last_pc + (last_c ? 2 : 4) modulo 2^32; otherwise SEQ (6).
  - Latch last_pc=next_pc, last_c=instr_c; clear first_instr; go to WAIT_DECODE; set nf=0.
- Same-cycle rule: a transfer coinciding with the fetch_valid consumption is stored in slot 0 and nf becomes 1. This is prefetch for the next instruction, and its address check uses the current next_pc.
- State WAIT_DECODE:
  - decode_complete: instr_count increments (wraps); go to IDLE.
  - fetch_valid without decode_complete raises PROTO (5).
  - Transfers continue to accumulate as prefetch.
- decode_complete while in IDLE raises SPURIOUS (4).
- Multiple violations in one cycle: err_pulse=1; err_code latches the lowest-numbered code, and only if err_sticky was 0.
- Errors never change state or counters beyond the rules above; checking continues.
- Reset asserted mid-instruction: the buffer is discarded and everything returns to reset values next cycle.
- Outputs are registered: err_pulse appears the cycle after the offending event.

Optional Feature:
FWRISC_FETCH_CHECKER_DATA_EN:
- Defined: at fetch_valid in IDLE, the expected instruction is built from the buffer and compared with instr. A mismatch raises DATA (7).
  - Aligned (next_pc[1]=0): compare slot0 data[31:0].
  - next_pc[1]=1, compressed: compare slot0 data[31:16] with instr[15:0].
  - next_pc[1]=1, 32-bit: compare {slot1[15:0], slot0[31:16]}.
  - When instr_c=1, only instr[15:0] is compared.
  - The check is skipped if COUNT fired in the same cycle.
- Undefined: no data registers are kept (address-only buffer) and code 7 is never produced.

Test Plan:
- next_pc=0x100, one fetch iaddr=0x100, fetch_valid with instr_c=0, then decode_complete -> no error; instr_count=1, fetch_count=1.
- next_pc=0x102, instr_c=0, fetches at 0x100 then 0x104 -> no error. Repeat with only one fetch -> err_code=3, err_pulse for one cycle, err_sticky=1.
- Three transfers with no fetch_valid (FETCH_DEPTH=2) -> err_code=1; fetch_count=3.
- Previous instr at 0x200 with instr_c=1; next fetch_valid has next_pc_seq=1, next_pc=0x204 -> err_code=6. Repeat with next_pc=0x202 -> clean.
- decode_complete in IDLE together with bad-address fetch 0x108 for next_pc=0x100 -> err_code=2 (lowest wins), err_pulse=1.
- DATA_EN defined, next_pc=0x102, instr_c=1, slot0 data=0xABCD_1234, instr[15:0]=0xABCD -> clean; instr[15:0]=0x1234 -> err_code=7.

Source files
------------

// File: rtl/fwrisc_fetch_stream_checker.sv
// Fetch-stream checker for fwrisc: tracks bus word transfers against delivered instructions.
// Define FWRISC_FETCH_CHECKER_DATA_EN to also keep fetched data and compare instruction content.
module fwrisc_fetch_stream_checker #(
   parameter int          FETCH_DEPTH = 2,
   parameter int          COUNT_W     = 8,
   parameter logic [31:0] RESET_PC    = 32'h8000_0000
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [31:0]        next_pc,
   input  logic               next_pc_seq,
   input  logic [31:0]        iaddr,
   input  logic [31:0]        idata,
   input  logic               ivalid,
   input  logic               iready,
   input  logic               fetch_valid,
   input  logic               decode_complete,
   input  logic [31:0]        instr,
   input  logic               instr_c,
   output logic               err_pulse,
   output logic               err_sticky,
   output logic [2:0]         err_code,
   output logic [COUNT_W-1:0] instr_count,
   output logic [COUNT_W-1:0] fetch_count
);

   localparam int NF_W = $clog2(FETCH_DEPTH + 1);

   typedef enum logic {
      IDLE,
      WAIT_DECODE
   } state_t;

   state_t          state;
   logic [NF_W-1:0] nf;
   logic            first_instr;
   logic [31:0]     last_pc;
   logic            last_c;
   logic [31:0]     buf_addr [FETCH_DEPTH];

   logic            xfer;
   logic            consume;
   logic            full;
   logic            store;
   logic [NF_W-1:0] slot_idx;
   logic [NF_W-1:0] exp_cnt;
   logic [31:0]     prev_addr;
   logic [31:0]     exp_addr;
   logic [31:0]     seq_pc;
   logic            err_overflow;
   logic            err_addr;
   logic            err_count;
   logic            err_spurious;
   logic            err_proto;
   logic            err_seq;
   logic            err_data;
   logic            err_any;
   logic [2:0]      first_code;

   // A transfer in the same cycle as consumption is prefetch for the next instruction: slot 0.
   assign xfer     = ivalid && iready;
   assign consume  = (state == IDLE) && fetch_valid;
   assign slot_idx = consume ? '0 : nf;
   assign full     = !consume && (nf == NF_W'(FETCH_DEPTH));
   assign store    = xfer && !full;

   always_comb begin
      prev_addr = '0;
      for (int k = 0; k < FETCH_DEPTH; k++) begin
         if (nf == NF_W'(k + 1)) prev_addr = buf_addr[k];
      end
   end

   assign exp_addr     = (slot_idx == '0) ? {next_pc[31:2], 2'b00} : prev_addr + 32'd4;
   assign exp_cnt      = (next_pc[1] && !instr_c) ? NF_W'(2) : NF_W'(1);
   assign seq_pc       = last_pc + (last_c ? 32'd2 : 32'd4);

   assign err_overflow = xfer && full;
   assign err_addr     = store && (iaddr != exp_addr);
   assign err_count    = consume && (nf != exp_cnt);
   assign err_spurious = (state == IDLE) && decode_complete;
   assign err_proto    = (state == WAIT_DECODE) && fetch_valid && !decode_complete;
   assign err_seq      = consume && next_pc_seq && !first_instr && (next_pc != seq_pc);

`ifdef FWRISC_FETCH_CHECKER_DATA_EN
   logic [31:0] buf_data [FETCH_DEPTH];
   logic        data_bad;

   // Misaligned 32-bit instructions straddle slot 0's upper half and slot 1's lower half.
   always_comb begin
      if (instr_c) begin
         data_bad = instr[15:0] != (next_pc[1] ? buf_data[0][31:16] : buf_data[0][15:0]);
      end else begin
         data_bad = instr != (next_pc[1] ? {buf_data[1][15:0], buf_data[0][31:16]} : buf_data[0]);
      end
   end

   assign err_data = consume && !err_count && data_bad;

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k < FETCH_DEPTH; k++) buf_data[k] <= '0;
      end else begin
         for (int k = 0; k < FETCH_DEPTH; k++) begin
            if (store && (slot_idx == NF_W'(k))) buf_data[k] <= idata;
         end
      end
   end
`else
   logic unused_data;
   assign unused_data = ^{idata, instr};
   assign err_data    = 1'b0;
`endif

   assign err_any = err_overflow || err_addr || err_count || err_spurious ||
                    err_proto || err_seq || err_data;

   always_comb begin
      first_code = 3'd0;
      if      (err_overflow) first_code = 3'd1;
      else if (err_addr)     first_code = 3'd2;
      else if (err_count)    first_code = 3'd3;
      else if (err_spurious) first_code = 3'd4;
      else if (err_proto)    first_code = 3'd5;
      else if (err_seq)      first_code = 3'd6;
      else if (err_data)     first_code = 3'd7;
   end

   // Errors are reported only; state and counters follow the normal rules regardless.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         nf          <= '0;
         first_instr <= 1'b1;
         last_pc     <= RESET_PC;
         last_c      <= 1'b0;
         err_pulse   <= 1'b0;
         err_sticky  <= 1'b0;
         err_code    <= 3'd0;
         instr_count <= '0;
         fetch_count <= '0;
         for (int k = 0; k < FETCH_DEPTH; k++) buf_addr[k] <= '0;
      end else begin
         err_pulse <= err_any;
         if (err_any && !err_sticky) begin
            err_sticky <= 1'b1;
            err_code   <= first_code;
         end

         if (xfer) fetch_count <= fetch_count + COUNT_W'(1);

         for (int k = 0; k < FETCH_DEPTH; k++) begin
            if (store && (slot_idx == NF_W'(k))) buf_addr[k] <= iaddr;
         end

         if (consume) begin
            nf <= xfer ? NF_W'(1) : '0;
         end else if (store) begin
            nf <= nf + NF_W'(1);
         end

         case (state)
            IDLE: begin
               if (fetch_valid) begin
                  last_pc     <= next_pc;
                  last_c      <= instr_c;
                  first_instr <= 1'b0;
                  state       <= WAIT_DECODE;
               end
            end
            WAIT_DECODE: begin
               if (decode_complete) begin
                  instr_count <= instr_count + COUNT_W'(1);
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fwrisc_fetch_stream_checker.sv
// Directed, table-driven bench for fwrisc_fetch_stream_checker; data-check expectations
// follow FWRISC_FETCH_CHECKER_DATA_EN when it is defined.
module tb_fwrisc_fetch_stream_checker;

`ifdef FWRISC_FETCH_CHECKER_DATA_EN
   localparam bit DATA_EN = 1'b1;
`else
   localparam bit DATA_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] next_pc;
   logic        next_pc_seq;
   logic [31:0] iaddr;
   logic [31:0] idata;
   logic        ivalid;
   logic        iready;
   logic        fetch_valid;
   logic        decode_complete;
   logic [31:0] instr;
   logic        instr_c;
   logic        err_pulse;
   logic        err_sticky;
   logic [2:0]  err_code;
   logic [7:0]  instr_count;
   logic [7:0]  fetch_count;

   int checks   = 0;
   int failures = 0;

   fwrisc_fetch_stream_checker #(
      .FETCH_DEPTH(2),
      .COUNT_W    (8),
      .RESET_PC   (32'h8000_0000)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .next_pc        (next_pc),
      .next_pc_seq    (next_pc_seq),
      .iaddr          (iaddr),
      .idata          (idata),
      .ivalid         (ivalid),
      .iready         (iready),
      .fetch_valid    (fetch_valid),
      .decode_complete(decode_complete),
      .instr          (instr),
      .instr_c        (instr_c),
      .err_pulse      (err_pulse),
      .err_sticky     (err_sticky),
      .err_code       (err_code),
      .instr_count    (instr_count),
      .fetch_count    (fetch_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      string       name;
      logic        rst;
      logic [31:0] pc;
      logic        seq;
      logic        iv;
      logic        ir;
      logic [31:0] ia;
      logic [31:0] id;
      logic        fv;
      logic        dc;
      logic [31:0] ins;
      logic        ic;
      logic        e_pulse;
      logic        e_sticky;
      logic [2:0]  e_code;
      logic [7:0]  e_icnt;
      logic [7:0]  e_fcnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(string name, logic rst, logic [31:0] pc, logic seq,
                               logic iv, logic ir, logic [31:0] ia, logic [31:0] id,
                               logic fv, logic dc, logic [31:0] ins, logic ic,
                               logic ep, logic es, logic [2:0] ec,
                               logic [7:0] ei, logic [7:0] ef);
      vec_t v;
      v.name = name; v.rst = rst; v.pc = pc; v.seq = seq; v.iv = iv; v.ir = ir;
      v.ia = ia; v.id = id; v.fv = fv; v.dc = dc; v.ins = ins; v.ic = ic;
      v.e_pulse = ep; v.e_sticky = es; v.e_code = ec; v.e_icnt = ei; v.e_fcnt = ef;
      return v;
   endfunction

   function automatic vec_t rst_vec(string name);
      return mk(name, 1, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 3'd0, 8'd0, 8'd0);
   endfunction

   // Drive one cycle of inputs, then settle just past the active edge.
   task automatic applyStimulus(input vec_t v);
      reset           = v.rst;
      next_pc         = v.pc;
      next_pc_seq     = v.seq;
      ivalid          = v.iv;
      iready          = v.ir;
      iaddr           = v.ia;
      idata           = v.id;
      fetch_valid     = v.fv;
      decode_complete = v.dc;
      instr           = v.ins;
      instr_c         = v.ic;
      @(posedge clock);
      #1;
   endtask

   task automatic check1(input string name, input string what,
                         input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s %s actual=0x%0h required=0x%0h", name, what, act, exp);
      end
   endtask

   task automatic checkOutput(input vec_t v);
      check1(v.name, "err_pulse",   32'(err_pulse),   32'(v.e_pulse));
      check1(v.name, "err_sticky",  32'(err_sticky),  32'(v.e_sticky));
      check1(v.name, "err_code",    32'(err_code),    32'(v.e_code));
      check1(v.name, "instr_count", 32'(instr_count), 32'(v.e_icnt));
      check1(v.name, "fetch_count", 32'(fetch_count), 32'(v.e_fcnt));
   endtask

   initial begin
      vec_t       v;
      logic       dp;
      logic [2:0] dcode;

      dp    = DATA_EN;
      dcode = DATA_EN ? 3'd7 : 3'd0;

      // Aligned single fetch; a request without iready must not count.
      vecs.push_back(rst_vec("a_rst"));
      vecs.push_back(mk("a_noready", 0, 32'h100, 0, 1, 0, 32'h100, 32'h13, 0, 0, 0, 0, 0, 0, 3'd0, 8'd0, 8'd0));
      vecs.push_back(mk("a_fetch",   0, 32'h100, 0, 1, 1, 32'h100, 32'h13, 0, 0, 0, 0, 0, 0, 3'd0, 8'd0, 8'd1));
      vecs.push_back(mk("a_fv",      0, 32'h100, 0, 0, 0, 0, 0, 1, 0, 32'h13, 0,  0, 0, 3'd0, 8'd0, 8'd1));
      vecs.push_back(mk("a_dc",      0, 32'h100, 0, 0, 0, 0, 0, 0, 1, 0, 0,       0, 0, 3'd0, 8'd1, 8'd1));
      // Misaligned 32-bit needs two words; then one word only -> COUNT.
      vecs.push_back(mk("b_f0", 0, 32'h102, 0, 1, 1, 32'h100, 32'hAAAA_0000, 0, 0, 0, 0, 0, 0, 3'd0, 8'd1, 8'd2));
      vecs.push_back(mk("b_f1", 0, 32'h102, 0, 1, 1, 32'h104, 32'h0000_BBBB, 0, 0, 0, 0, 0, 0, 3'd0, 8'd1, 8'd3));
      vecs.push_back(mk("b_fv", 0, 32'h102, 0, 0, 0, 0, 0, 1, 0, 32'hBBBB_AAAA, 0, 0, 0, 3'd0, 8'd1, 8'd3));
      vecs.push_back(mk("b_dc", 0, 32'h102, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3'd0, 8'd2, 8'd3));
      vecs.push_back(mk("b_f2", 0, 32'h106, 0, 1, 1, 32'h104, 32'h1111_2222, 0, 0, 0, 0, 0, 0, 3'd0, 8'd2, 8'd4));
      vecs.push_back(mk("b_cnt", 0, 32'h106, 1, 0, 0, 0, 0, 1, 0, 32'h0, 0, 1, 1, 3'd3, 8'd2, 8'd4));
      vecs.push_back(mk("b_dc2", 0, 32'h106, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 3'd3, 8'd3, 8'd4));
      // Three transfers into a two-slot buffer -> OVERFLOW.
      vecs.push_back(rst_vec("c_rst"));
      vecs.push_back(mk("c_f0", 0, 32'h100, 0, 1, 1, 32'h100, 32'h1, 0, 0, 0, 0, 0, 0, 3'd0, 8'd0, 8'd1));
      vecs.push_back(mk("c_f1", 0, 32'h100, 0, 1, 1, 32'h104, 32'h2, 0, 0, 0, 0, 0, 0, 3'd0, 8'd0, 8'd2));
      vecs.push_back(mk("c_ovf", 0, 32'h100, 0, 1, 1, 32'h108, 32'h3, 0, 0, 0, 0, 1, 1, 3'd1, 8'd0, 8'd3));
      vecs.push_back(mk("c_idle", 0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'd1, 8'd0, 8'd3));
      // Compressed at 0x200 followed by sequential 0x204 -> SEQ.
      vecs.push_back(rst_vec("d_rst"));
      vecs.push_back(mk("d_f0", 0, 32'h200, 0, 1, 1, 32'h200, 32'h0000_4501, 0, 0, 0, 0, 0, 0, 3'd0, 8'd0, 8'd1));
      vecs.push_back(mk("d_fv0", 0, 32'h200, 0, 0, 0, 0, 0, 1, 0, 32'hFFFF_4501, 1, 0, 0, 3'd0, 8'd0, 8'd1));
      vecs.push_back(mk("d_dc0", 0, 32'h200, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3'd0, 8'd1, 8'd1));
      vecs.push_back(mk("d_f1", 0, 32'h204, 0, 1, 1, 32'h204, 32'h1, 0, 0, 0, 0, 0, 0, 3'd0, 8'd1, 8'd2));
      vecs.push_back(mk("d_seq", 0, 32'h204, 1, 0, 0, 0, 0, 1, 0, 32'h1, 0, 1, 1, 3'd6, 8'd1, 8'd2));
      vecs.push_back(mk("d_dc1", 0, 32'h204, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 3'd6, 8'd2, 8'd2));
      // Same, but the sequential PC 0x202 is correct.
      vecs.push_back(rst_vec("e_rst"));
      vecs.push_back(mk("e_f0", 0, 32'h200, 0, 1, 1, 32'h200, 32'h0000_4501, 0, 0, 0, 0, 0, 0, 3'd0, 8'd0, 8'd1));
      vecs.push_back(mk("e_fv0", 0, 32'h200, 0, 0, 0, 0, 0, 1, 0, 32'h0000_4501, 1, 0, 0, 3'd0, 8'd0, 8'd1));
      vecs.push_back(mk("e_dc0", 0, 32'h200, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3'd0, 8'd1, 8'd1));
      vecs.push_back(mk("e_f1", 0, 32'h202, 0, 1, 1, 32'h200, 32'h4502_4501, 0, 0, 0, 0, 0, 0, 3'd0, 8'd1, 8'd2));
      vecs.push_back(mk("e_fv1", 0, 32'h202, 1, 0, 0, 0, 0, 1, 0, 32'h0000_4502, 1, 0, 0, 3'd0, 8'd1, 8'd2));
      vecs.push_back(mk("e_dc1", 0, 32'h202, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3'd0, 8'd2, 8'd2));
      // Bad address together with decode_complete in IDLE: ADDR beats SPURIOUS.
      vecs.push_back(rst_vec("f_rst"));
      vecs.push_back(mk("f_multi", 0, 32'h100, 0, 1, 1, 32'h108, 32'h0, 0, 1, 0, 0, 1, 1, 3'd2, 8'd0, 8'd1));
      vecs.push_back(mk("f_idle", 0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'd2, 8'd0, 8'd1));
      // Content check on the upper half of slot 0.
      vecs.push_back(rst_vec("g_rst"));
      vecs.push_back(mk("g_f0", 0, 32'h102, 0, 1, 1, 32'h100, 32'hABCD_1234, 0, 0, 0, 0, 0, 0, 3'd0, 8'd0, 8'd1));
      vecs.push_back(mk("g_ok", 0, 32'h102, 0, 0, 0, 0, 0, 1, 0, 32'h0000_ABCD, 1, 0, 0, 3'd0, 8'd0, 8'd1));
      vecs.push_back(mk("g_dc", 0, 32'h102, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3'd0, 8'd1, 8'd1));
      vecs.push_back(rst_vec("h_rst"));
      vecs.push_back(mk("h_f0", 0, 32'h102, 0, 1, 1, 32'h100, 32'hABCD_1234, 0, 0, 0, 0, 0, 0, 3'd0, 8'd0, 8'd1));
      vecs.push_back(mk("h_data", 0, 32'h102, 0, 0, 0, 0, 0, 1, 0, 32'h0000_1234, 1, dp, dp, dcode, 8'd0, 8'd1));
      vecs.push_back(mk("h_dc", 0, 32'h102, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, dp, dcode, 8'd1, 8'd1));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkOutput(vecs[i]);
      end

      // Transfer in the consumption cycle lands in slot 0 and serves the next instruction.
      v = rst_vec("s_rst");                                                                  applyStimulus(v); checkOutput(v);
      v = mk("s_f0", 0, 32'h100, 0, 1, 1, 32'h100, 32'h13, 0, 0, 0, 0, 0, 0, 3'd0, 8'd0, 8'd1); applyStimulus(v); checkOutput(v);
      v = mk("s_fvpre", 0, 32'h100, 0, 1, 1, 32'h100, 32'h0040_0093, 1, 0, 32'h13, 0, 0, 0, 3'd0, 8'd0, 8'd2); applyStimulus(v); checkOutput(v);
      v = mk("s_dc0", 0, 32'h100, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3'd0, 8'd1, 8'd2);         applyStimulus(v); checkOutput(v);
      v = mk("s_fv1", 0, 32'h104, 1, 0, 0, 0, 0, 1, 0, 32'h0040_0093, 0, 0, 0, 3'd0, 8'd1, 8'd2); applyStimulus(v); checkOutput(v);
      v = mk("s_dc1", 0, 32'h104, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3'd0, 8'd2, 8'd2);         applyStimulus(v); checkOutput(v);

      // fetch_valid again while waiting for decode -> PROTO; prefetch meanwhile still counts.
      v = rst_vec("p_rst");                                                                  applyStimulus(v); checkOutput(v);
      v = mk("p_f0", 0, 32'h100, 0, 1, 1, 32'h100, 32'h13, 0, 0, 0, 0, 0, 0, 3'd0, 8'd0, 8'd1); applyStimulus(v); checkOutput(v);
      v = mk("p_fv0", 0, 32'h100, 0, 0, 0, 0, 0, 1, 0, 32'h13, 0, 0, 0, 3'd0, 8'd0, 8'd1);    applyStimulus(v); checkOutput(v);
      v = mk("p_proto", 0, 32'h100, 0, 1, 1, 32'h100, 32'h33, 1, 0, 0, 0, 1, 1, 3'd5, 8'd0, 8'd2); applyStimulus(v); checkOutput(v);
      v = mk("p_fvdc", 0, 32'h100, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 3'd5, 8'd1, 8'd2);        applyStimulus(v); checkOutput(v);
      v = mk("p_fv1", 0, 32'h100, 0, 0, 0, 0, 0, 1, 0, 32'h33, 0, 0, 1, 3'd5, 8'd1, 8'd2);    applyStimulus(v); checkOutput(v);
      v = mk("p_dc1", 0, 32'h100, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 3'd5, 8'd2, 8'd2);         applyStimulus(v); checkOutput(v);

      // 256 transfers wrap fetch_count back to zero; overflow keeps pulsing.
      v = rst_vec("w_rst");
      applyStimulus(v);
      checkOutput(v);
      for (int i = 0; i < 256; i++) begin
         v = mk("w_xfer", 0, 32'h100, 0, 1, 1, 32'h100 + 32'(i * 4), 32'h0, 0, 0, 0, 0,
                1, 1, 3'd1, 8'd0, 8'd0);
         applyStimulus(v);
      end
      checkOutput(v);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
